// File: rtl/ci_initiator_if.sv
// rtl/ci_initiator_if.sv - request, CI bus and response signals of the CI initiator
interface ci_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_ci_n;
  logic [31:0] req_value_a;
  logic [31:0] req_value_b;

  logic        ci_start;
  logic [7:0]  ci_n;
  logic [31:0] ci_value_a;
  logic [31:0] ci_value_b;
  logic        ci_done;
  logic [31:0] ci_result;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_timeout;

  modport master (
    input  req_valid, req_ci_n, req_value_a, req_value_b,
    output req_ready,
    output ci_start, ci_n, ci_value_a, ci_value_b,
    input  ci_done, ci_result,
    output resp_valid, resp_result, resp_timeout,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_ci_n, req_value_a, req_value_b,
    input  req_ready,
    input  ci_start, ci_n, ci_value_a, ci_value_b,
    output ci_done, ci_result,
    input  resp_valid, resp_result, resp_timeout,
    output resp_ready
  );
endinterface

// File: rtl/ci_initiator.sv
// rtl/ci_initiator.sv - CI bus master: one transaction at a time, result or timeout returned as a response
module ci_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           i_clock,
  input  logic           i_reset,
  ci_initiator_if.master bus,
  output logic           o_busy,
  output logic [7:0]     o_timeout_count
);

  localparam int WCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT_CYCLES > 0) ? WCW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit NO_WAIT = (TIMEOUT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [WCW-1:0]  r_wait_cnt;
  logic            r_req_ready;
  logic            r_ci_start;
  logic [7:0]      r_ci_n;
  logic [31:0]     r_ci_value_a;
  logic [31:0]     r_ci_value_b;
  logic            r_resp_valid;
  logic [31:0]     r_resp_result;
  logic            r_resp_timeout;
  logic            r_busy;
  logic [7:0]      r_timeout_count;

  logic            w_in_flight;
  logic            w_done_seen;
  logic            w_give_up;
  logic            w_to_resp;

  // Done wins over the timeout when both land in the same cycle.
  always_comb begin
    w_in_flight = (r_state == S_ISSUE) || (r_state == S_WAIT);
    w_done_seen = w_in_flight && bus.ci_done;
    w_give_up   = !bus.ci_done &&
                  (((r_state == S_ISSUE) && NO_WAIT) ||
                   ((r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST)));
    w_to_resp   = w_done_seen || w_give_up;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state         <= S_IDLE;
      r_wait_cnt      <= '0;
      r_req_ready     <= 1'b1;
      r_ci_start      <= 1'b0;
      r_ci_n          <= '0;
      r_ci_value_a    <= '0;
      r_ci_value_b    <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_result   <= '0;
      r_resp_timeout  <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_state      <= S_ISSUE;
            r_req_ready  <= 1'b0;
            r_ci_start   <= 1'b1;
            r_busy       <= 1'b1;
            r_ci_n       <= bus.req_ci_n;
            r_ci_value_a <= bus.req_value_a;
            r_ci_value_b <= bus.req_value_b;
          end
        end
        S_ISSUE: begin
          r_ci_start <= 1'b0;
          if (!w_to_resp) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!w_to_resp) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state        <= S_IDLE;
            r_resp_valid   <= 1'b0;
            r_resp_result  <= '0;
            r_resp_timeout <= 1'b0;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Common entry into RESP from either ISSUE or WAIT; operands are released here.
      if (w_to_resp) begin
        r_state        <= S_RESP;
        r_resp_valid   <= 1'b1;
        r_resp_result  <= w_done_seen ? bus.ci_result : 32'd0;
        r_resp_timeout <= w_give_up;
        r_ci_n         <= '0;
        r_ci_value_a   <= '0;
        r_ci_value_b   <= '0;
        if (w_give_up && (r_timeout_count != 8'hFF)) begin
          r_timeout_count <= r_timeout_count + 8'd1;
        end
      end
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.ci_start     = r_ci_start;
  assign bus.ci_n         = r_ci_n;
  assign bus.ci_value_a   = r_ci_value_a;
  assign bus.ci_value_b   = r_ci_value_b;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_result  = r_resp_result;
  assign bus.resp_timeout = r_resp_timeout;
  assign o_busy           = r_busy;
  assign o_timeout_count  = r_timeout_count;

endmodule
